// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared definitions for the pipelined carry-lookahead adder.
//                GROUP_W   - width of one lookahead group (one pipeline stage)
//                cla_grp_t - operand/sum slices plus group propagate/generate
//                ovf_calc  - signed overflow from the MSB of a group
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic [GROUP_W-1:0] a;
        logic [GROUP_W-1:0] b;
        logic [GROUP_W-1:0] sum;
        logic               p;
        logic               g;
    } cla_grp_t;

    // The carry into the MSB is recovered from the MSB sum bit
    // (s = a ^ b ^ cin), so only the carry out needs to be passed in.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic cout
    );
        return (a_msb ^ b_msb ^ s_msb) ^ cout;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_group.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_group
//  Description : Combinational 4-bit carry-lookahead adder slice.
//                Ports: a, b (operand slices), cin (carry in),
//                       s (sum slice), cout (carry out),
//                       p / g (group propagate / generate)
//  Revision    : 1.0 - initial release
// ============================================================================
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               cout,
    output logic               p,
    output logic               g
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Flat lookahead equations: every internal carry depends only on cin
    // and the bit-level p/g terms, never on a rippled carry.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign p    = &w_p;
    assign g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign cout = g | (p & cin);
    assign s    = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined WIDTH-bit carry-lookahead adder/subtractor, one
//                4-bit group per stage, valid/ready handshake with a global
//                stall enable.
//                Inputs : clk, reset (async, active-high), in_valid, a_in,
//                         b_in, c_in, sub_in, out_ready
//                Outputs: in_ready, out_valid, s, c_out, ovf
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NGROUPS = WIDTH / GROUP_W;

    // Operand and sum registers are stored as triangles: after stage k only
    // the operand bits of groups above k still travel, and only the sum bits
    // of groups 0..k exist. op_off/s_off give each stage's slice offset.
    function automatic int op_off(input int k);
        return k * WIDTH - (GROUP_W * k * (k + 1)) / 2;
    endfunction

    function automatic int s_off(input int k);
        return (GROUP_W * k * (k + 1)) / 2;
    endfunction

    localparam int OP_BITS = (NGROUPS > 1) ? op_off(NGROUPS - 1) : 1;
    localparam int S_BITS  = s_off(NGROUPS);
    localparam int S_LAST  = s_off(NGROUPS - 1);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [NGROUPS-1:0] r_v;
    logic [NGROUPS-1:0] r_c;
    logic [OP_BITS-1:0] r_a;
    logic [OP_BITS-1:0] r_b;
    logic [S_BITS-1:0]  r_s;
    logic               r_ovf;

    logic [NGROUPS-1:0] w_v_nxt;
    logic [NGROUPS-1:0] w_c_nxt;
    logic [OP_BITS-1:0] w_a_nxt;
    logic [OP_BITS-1:0] w_b_nxt;
    logic [S_BITS-1:0]  w_s_nxt;
    logic               w_ovf_nxt;
    logic               w_en;

    // The whole pipeline advances together; it only freezes when a result
    // is waiting and downstream refuses it.
    assign w_en     = !r_v[NGROUPS-1] || out_ready;
    assign in_ready = w_en && !reset;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
        localparam int OP_W = WIDTH - GROUP_W * k;

        logic [OP_W-1:0] w_a_op;
        logic [OP_W-1:0] w_b_op;
        logic            w_cin;
        logic            w_cout;
        cla_grp_t        w_grp;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1: invert B once here and force the
            // carry in, so later stages need no knowledge of the mode.
            assign w_a_op     = a_in;
            assign w_b_op     = b_in ^ {WIDTH{sub_in}};
            assign w_cin      = sub_in | c_in;
            assign w_v_nxt[0] = in_valid && in_ready;
            assign w_s_nxt[GROUP_W-1:0] = w_grp.sum;
        end else begin : g_next
            assign w_a_op     = r_a[op_off(k-1) +: OP_W];
            assign w_b_op     = r_b[op_off(k-1) +: OP_W];
            assign w_cin      = r_c[k-1];
            assign w_v_nxt[k] = r_v[k-1];
            assign w_s_nxt[s_off(k) +: GROUP_W*k]         = r_s[s_off(k-1) +: GROUP_W*k];
            assign w_s_nxt[s_off(k) + GROUP_W*k +: GROUP_W] = w_grp.sum;
        end

        if (k < NGROUPS - 1) begin : g_fwd
            assign w_a_nxt[op_off(k) +: OP_W-GROUP_W] = w_a_op[OP_W-1:GROUP_W];
            assign w_b_nxt[op_off(k) +: OP_W-GROUP_W] = w_b_op[OP_W-1:GROUP_W];
        end

        assign w_grp.a = w_a_op[GROUP_W-1:0];
        assign w_grp.b = w_b_op[GROUP_W-1:0];

        cla4_group u_grp (
            .a    (w_grp.a),
            .b    (w_grp.b),
            .cin  (w_cin),
            .s    (w_grp.sum),
            .cout (w_cout),
            .p    (w_grp.p),
            .g    (w_grp.g)
        );

        assign w_c_nxt[k] = w_cout;

        if (k == NGROUPS - 1) begin : g_last
            assign w_ovf_nxt = ovf_calc(w_grp.a[GROUP_W-1], w_grp.b[GROUP_W-1],
                                        w_grp.sum[GROUP_W-1], w_cout);
        end
    end

    if (NGROUPS == 1) begin : g_no_fwd
        assign w_a_nxt = '0;
        assign w_b_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v   <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_v   <= w_v_nxt;
            r_c   <= w_c_nxt;
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_s   <= w_s_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign out_valid = r_v[NGROUPS-1];
    assign s         = r_s[S_LAST +: WIDTH];
    assign c_out     = r_c[NGROUPS-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder, WIDTH=4 and
//                WIDTH=16 instances sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        reset;

    logic        iv16, ordy16, ci16, sb16;
    logic [15:0] a16, b16;
    logic        ir16, ov16, co16, ovf16;
    logic [15:0] s16;

    logic        iv4, ordy4, ci4, sb4;
    logic [3:0]  a4, b4;
    logic        ir4, ov4, co4, ovf4;
    logic [3:0]  s4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .a_in(a16), .b_in(b16), .c_in(ci16), .sub_in(sb16),
        .out_valid(ov16), .out_ready(ordy16), .s(s16), .c_out(co16), .ovf(ovf16)
    );

    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4),
        .a_in(a4), .b_in(b4), .c_in(ci4), .sub_in(sb4),
        .out_valid(ov4), .out_ready(ordy4), .s(s4), .c_out(co4), .ovf(ovf4)
    );

    // Reference: {ovf, carry, sum} from plain 17-bit arithmetic.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        logic        ov;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? 1'b1 : cin)};
        ov   = (a[15] == be[15]) && (full[15] != a[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({ov16, s16, co16, ovf16, ir16} !== 20'd0) begin
            bad++;
            $display("FAIL reset16 got v=%b s=%h c=%b o=%b ir=%b want all 0", ov16, s16, co16, ovf16, ir16);
        end
        total++;
        if ({ov4, s4, co4, ovf4, ir4} !== 8'd0) begin
            bad++;
            $display("FAIL reset4 got v=%b s=%h c=%b o=%b ir=%b want all 0", ov4, s4, co4, ovf4, ir4);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (ir16 !== 1'b1 || ir4 !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got ir16=%b ir4=%b want 1 1", ir16, ir4);
        end
    endtask

    task automatic test_w4();
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hA; b4 = 4'h5; ci4 = 1'b0; sb4 = 1'b0;
        @(negedge clk);
        total++;
        if (ov4 !== 1'b1 || s4 !== 4'hF || co4 !== 1'b0 || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL w4_add1 got v=%b s=%h c=%b o=%b want v=1 s=f c=0 o=0", ov4, s4, co4, ovf4);
        end
        a4 = 4'h9; b4 = 4'h9; ci4 = 1'b1;
        @(negedge clk);
        total++;
        if (ov4 !== 1'b1 || s4 !== 4'h3 || co4 !== 1'b1 || ovf4 !== 1'b1) begin
            bad++;
            $display("FAIL w4_add2 got v=%b s=%h c=%b o=%b want v=1 s=3 c=1 o=1", ov4, s4, co4, ovf4);
        end
        iv4 = 1'b0;
        @(negedge clk);
        total++;
        if (ov4 !== 1'b0) begin
            bad++;
            $display("FAIL w4_drain got v=%b want 0", ov4);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vsub [4];
        logic [15:0] es [4];
        logic        ec [4];
        logic        eo [4];
        va = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        vsub = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1};
        ordy16 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (c >= 4 && c < 8) begin
                if (ov16 !== 1'b1 || s16 !== es[c-4] || co16 !== ec[c-4] || ovf16 !== eo[c-4]) begin
                    bad++;
                    $display("FAIL b2b[%0d] got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                             c-4, ov16, s16, co16, ovf16, es[c-4], ec[c-4], eo[c-4]);
                end
            end else if (ov16 !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle cycle %0d got v=%b want 0", c, ov16);
            end
            if (c < 4) begin
                iv16 = 1'b1; a16 = va[c]; b16 = vb[c]; sb16 = vsub[c]; ci16 = 1'b0;
            end else begin
                iv16 = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vsub [5];
        logic [17:0] q [$];
        logic [17:0] e;
        int          sent = 0;
        int          got  = 0;
        va = '{16'h1234, 16'h0100, 16'hFFFF, 16'h8000, 16'h4000};
        vb = '{16'h1111, 16'h0001, 16'hFFFF, 16'h8000, 16'h4000};
        vsub = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ordy16 = !(c >= 4 && c <= 6);
            iv16 = (sent < 5);
            if (sent < 5) begin
                a16 = va[sent]; b16 = vb[sent]; sb16 = vsub[sent]; ci16 = 1'b1;
            end
            #1;
            if (c >= 4 && c <= 6) begin
                e = model16(va[0], vb[0], 1'b1, vsub[0]);
                total++;
                if (ov16 !== 1'b1 || ir16 !== 1'b0 || s16 !== e[15:0]) begin
                    bad++;
                    $display("FAIL stall cycle %0d got v=%b ir=%b s=%h want v=1 ir=0 s=%h",
                             c, ov16, ir16, s16, e[15:0]);
                end
            end
            if (ov16 && ordy16) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra got s=%h want no output", s16);
                end else begin
                    e = q.pop_front();
                    got++;
                    if ({ovf16, co16, s16} !== e) begin
                        bad++;
                        $display("FAIL bp_result[%0d] got %h want %h", got-1, {ovf16, co16, s16}, e);
                    end
                end
            end
            if (iv16 && ir16) begin
                q.push_back(model16(a16, b16, ci16, sb16));
                sent++;
            end
        end
        iv16 = 1'b0;
        ordy16 = 1'b1;
        total++;
        if (got != 5 || q.size() != 0) begin
            bad++;
            $display("FAIL bp_count got %0d want 5", got);
        end
    endtask

    task automatic test_bubbles();
        ordy16 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (ov16 !== (c == 4 || c == 6)) begin
                bad++;
                $display("FAIL bubble_valid cycle %0d got %b want %b", c, ov16, (c == 4 || c == 6));
            end
            if (c == 4) begin
                total++;
                if (s16 !== 16'h0003 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
                    bad++;
                    $display("FAIL bubble_s0 got s=%h c=%b o=%b want s=0003 c=0 o=0", s16, co16, ovf16);
                end
            end
            if (c == 6) begin
                total++;
                if (s16 !== 16'h00E1 || co16 !== 1'b1 || ovf16 !== 1'b0) begin
                    bad++;
                    $display("FAIL bubble_s1 got s=%h c=%b o=%b want s=00e1 c=1 o=0", s16, co16, ovf16);
                end
            end
            iv16 = (c == 0 || c == 2);
            if (c == 0) begin a16 = 16'h0001; b16 = 16'h0002; sb16 = 1'b0; ci16 = 1'b0; end
            if (c == 2) begin a16 = 16'h00F0; b16 = 16'h000F; sb16 = 1'b1; ci16 = 1'b0; end
        end
    endtask

    task automatic test_reset_mid();
        ordy16 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0002 + 16'(c); sb16 = 1'b0; ci16 = 1'b0;
        end
        @(negedge clk);
        iv16 = 1'b0;
        ordy16 = 1'b0;
        #1;
        total++;
        if (ov16 !== 1'b1 || s16 !== 16'h0001 || co16 !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got v=%b s=%h c=%b want v=1 s=0001 c=1", ov16, s16, co16);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (ov16 !== 1'b0 || s16 !== 16'h0000 || co16 !== 1'b0 || ovf16 !== 1'b0 || ir16 !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async got v=%b s=%h c=%b o=%b ir=%b want all 0", ov16, s16, co16, ovf16, ir16);
        end
        @(negedge clk);
        reset = 1'b0;
        ordy16 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (ov16 !== (c == 6)) begin
                bad++;
                $display("FAIL rmid_valid cycle %0d got %b want %b", c, ov16, (c == 6));
            end
            if (c == 6) begin
                total++;
                if (s16 !== 16'h5555 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
                    bad++;
                    $display("FAIL rmid_result got s=%h c=%b o=%b want s=5555 c=0 o=0", s16, co16, ovf16);
                end
            end
            iv16 = (c == 2);
            if (c == 2) begin a16 = 16'h1234; b16 = 16'h4321; sb16 = 1'b0; ci16 = 1'b0; end
        end
    endtask

    task automatic test_random();
        localparam int NVEC = 1200;
        logic [17:0] q [$];
        logic [17:0] e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        while (got < NVEC && cyc < 8000) begin
            @(negedge clk);
            iv16   = (sent < NVEC) && ($urandom_range(0, 9) < 8);
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            ci16   = 1'($urandom_range(0, 1));
            sb16   = 1'($urandom_range(0, 1));
            ordy16 = ($urandom_range(0, 9) < 7);
            #1;
            if (ov16 && ordy16) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra got s=%h want no output", s16);
                end else begin
                    e = q.pop_front();
                    got++;
                    if ({ovf16, co16, s16} !== e) begin
                        bad++;
                        $display("FAIL rnd[%0d] got %h want %h", got-1, {ovf16, co16, s16}, e);
                    end
                end
            end
            if (iv16 && ir16) begin
                q.push_back(model16(a16, b16, ci16, sb16));
                sent++;
            end
            cyc++;
        end
        iv16 = 1'b0;
        ordy16 = 1'b1;
        total++;
        if (got != NVEC) begin
            bad++;
            $display("FAIL rnd_count got %0d want %0d", got, NVEC);
        end
    endtask

    initial begin
        reset = 1'b1;
        iv16 = 1'b0; ordy16 = 1'b1; ci16 = 1'b0; sb16 = 1'b0; a16 = '0; b16 = '0;
        iv4 = 1'b0;  ordy4 = 1'b1;  ci4 = 1'b0;  sb4 = 1'b0;  a4 = '0;  b4 = '0;
        test_reset();
        test_w4();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
